random_delay_timer: RTL and testbench
=====================================

RANDOM_DELAY_TIMER -- requirements
Module: random_delay_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, timing tick rate (1 ms tick).
REQ-003 SHALL have parameter MIN_DELAY_TICKS, default 1000, fixed delay added to the random value.
REQ-004 SHALL have parameter MAX_REACT_TICKS, default 9999, reaction-count saturation and timeout limit.
REQ-005 SHALL have clk50M  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have random_num  input  12  random delay value from the random-number generator.
REQ-008 SHALL have start  input  1  synchronous, debounced start request.
REQ-009 SHALL have react  input  1  synchronous, debounced user button.
REQ-010 SHALL have go  output  1  stimulus light; high while waiting for the user's reaction.
REQ-011 SHALL have busy  output  1  high while a run is in progress.
REQ-012 SHALL have done  output  1  one-cycle pulse when a run ends.
REQ-013 SHALL have false_start  output  1  sticky flag: run ended by an early press.
REQ-014 SHALL have timeout  output  1  sticky flag: no reaction within MAX_REACT_TICKS.
REQ-015 SHALL have reaction_ms  output  14  measured reaction time in ticks.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT_DELAY, WAIT_REACT and RESULT.
REQ-017 SHALL generate a one-cycle tick every CLK_HZ/TICK_HZ cycles; the prescaler SHALL clear on the accepted start.
REQ-018 In IDLE or RESULT with start=1: capture random_num that cycle, load delay = MIN_DELAY_TICKS + random_num, clear reaction_ms, false_start, timeout, and enter WAIT_DELAY.
REQ-019 The delay arithmetic SHALL be 14 bits wide; random_num=0 SHALL give a delay of exactly MIN_DELAY_TICKS.
REQ-020 WAIT_DELAY: decrement the delay on each tick; on the tick that takes it to 0, enter WAIT_REACT and assert go from the next cycle.
REQ-021 WAIT_REACT: increment reaction_ms on each tick; react=1 SHALL enter RESULT with reaction_ms frozen.
REQ-022 If react and tick coincide in WAIT_REACT, react SHALL win and reaction_ms SHALL NOT increment.
REQ-023 When reaction_ms reaches MAX_REACT_TICKS, the FSM SHALL enter RESULT with timeout=1 and reaction_ms=MAX_REACT_TICKS.
REQ-024 Entry into RESULT SHALL pulse done for exactly one cycle and deassert go and busy.
REQ-025 busy SHALL be high in WAIT_DELAY and WAIT_REACT only.
REQ-026 start SHALL be ignored while busy.
REQ-027 react SHALL be ignored in IDLE and RESULT.
REQ-028 RESULT SHALL hold its outputs until the next start.

Reset
REQ-029 Reset SHALL force IDLE, with go, busy, done, false_start and timeout at 0, reaction_ms=0, and the prescaler and delay counter cleared.
REQ-030 Reset asserted mid-run SHALL abort the run immediately; done SHALL NOT pulse.

Configuration
REQ-031 With RDT_FALSE_START_EN defined: react=1 in WAIT_DELAY SHALL enter RESULT with false_start=1, reaction_ms=0, go never asserted, and done pulsed.
REQ-032 Without RDT_FALSE_START_EN: react in WAIT_DELAY SHALL be ignored; false_start SHALL be tied to 0.

Structure
REQ-033 Package rdt_pkg SHALL hold the state enum typedef and the 14-bit count width constant.
REQ-034 The prescaler SHALL be the sub-module tick_gen (parameters CLK_HZ and TICK_HZ; ports clk50M, reset, clr, tick).

Verification (CLK_HZ=10, TICK_HZ=1, MIN_DELAY_TICKS=2, MAX_REACT_TICKS=20)
REQ-035 start with random_num=3 -> go rises after 5 ticks (50 cycles); react after 7 ticks -> reaction_ms=7, done pulses once.
REQ-036 random_num=0 -> go rises after exactly 2 ticks.
REQ-037 No react -> timeout=1, reaction_ms=20, done pulses, go falls.
REQ-038 react in WAIT_DELAY -> with the macro: false_start=1, reaction_ms=0; without it: the run continues and go rises on schedule.
REQ-039 react on the same cycle as a tick with reaction_ms=4 -> reaction_ms stays 4; start while busy -> no effect.
REQ-040 reset mid-WAIT_REACT -> all outputs 0 and no done; a following start runs normally.

Source files
------------

// File: rtl/rdt_pkg.sv
// Shared types and widths for the reaction-timer block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum and the common 14-bit count width used by the
// delay counter and the reaction counter.
package rdt_pkg;

   // Width of delay and reaction arithmetic; 14 bits covers up to 16383 ticks.
   localparam int COUNT_W = 14;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_DELAY = 2'd1,
      WAIT_REACT = 2'd2,
      RESULT     = 2'd3
   } rdt_state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
// Latency: first tick CLK_HZ/TICK_HZ cycles after the edge that samples clr.
// Backpressure: none; free-running except for the synchronous clr.
//
// Ports:
//   clk50M - clock, rising edge
//   reset  - asynchronous active-high reset, clears the count
//   clr    - synchronous restart of the count (phase-aligns ticks to a run start)
//   tick   - one-cycle pulse at the end of each period
module tick_gen #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 1000
) (
   input  logic clk50M,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int DIV = ((CLK_HZ / TICK_HZ) < 1) ? 1 : (CLK_HZ / TICK_HZ);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk50M or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Suppressed during clr so a restart never emits a stale tick.
   assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/random_delay_timer.sv
// Reaction timer: waits MIN_DELAY_TICKS+random_num ticks, lights go, counts ticks until react.
// Latency: go rises the cycle after the tick that ends the delay; done pulses the first cycle in RESULT.
// Backpressure: none; start is ignored while busy, react is ignored outside a run.
//
// Ports:
//   clk50M       - clock, rising edge
//   reset        - asynchronous active-high reset, aborts any run without a done pulse
//   random_num   - 12-bit random delay, captured on the accepted start
//   start        - start request (accepted in IDLE or RESULT)
//   react        - user button
//   go           - stimulus light, high in WAIT_REACT
//   busy         - high in WAIT_DELAY and WAIT_REACT
//   done         - one-cycle pulse on entry into RESULT
//   false_start  - sticky: run ended by a press during the delay
//   timeout      - sticky: no press within MAX_REACT_TICKS
//   reaction_ms  - measured reaction time in ticks
// Build option: RDT_FALSE_START_EN enables false-start detection; when
// undefined, react during the delay is ignored and false_start is tied low.
module random_delay_timer
   import rdt_pkg::*;
#(
   parameter int CLK_HZ          = 50000000,
   parameter int TICK_HZ         = 1000,
   parameter int MIN_DELAY_TICKS = 1000,
   parameter int MAX_REACT_TICKS = 9999
) (
   input  logic        clk50M,
   input  logic        reset,
   input  logic [11:0] random_num,
   input  logic        start,
   input  logic        react,
   output logic        go,
   output logic        busy,
   output logic        done,
   output logic        false_start,
   output logic        timeout,
   output logic [13:0] reaction_ms
);

   localparam logic [COUNT_W-1:0] MIN_D = COUNT_W'(MIN_DELAY_TICKS);
   localparam logic [COUNT_W-1:0] MAX_R = COUNT_W'(MAX_REACT_TICKS);
   localparam logic [COUNT_W-1:0] ONE   = COUNT_W'(1);

   rdt_state_t         state, nxt_state;
   logic [COUNT_W-1:0] delay_cnt, nxt_delay;
   logic [COUNT_W-1:0] react_cnt, nxt_react;
   logic [COUNT_W-1:0] react_inc;
   logic               timeout_q, nxt_timeout;
   logic               done_q;
   logic               start_acc;
   logic               tick;

   tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_tick_gen (
      .clk50M (clk50M),
      .reset  (reset),
      .clr    (start_acc),
      .tick   (tick)
   );

`ifdef RDT_FALSE_START_EN
   logic fs_q, nxt_fs;
`endif

   assign react_inc = react_cnt + 1'b1;

   always_comb begin
      nxt_state   = state;
      nxt_delay   = delay_cnt;
      nxt_react   = react_cnt;
      nxt_timeout = timeout_q;
      start_acc   = 1'b0;
      go          = 1'b0;
      busy        = 1'b0;
`ifdef RDT_FALSE_START_EN
      nxt_fs      = fs_q;
`endif
      case (state)
         IDLE, RESULT: begin
            if (start) begin
               start_acc   = 1'b1;
               nxt_delay   = MIN_D + COUNT_W'(random_num);
               nxt_react   = '0;
               nxt_timeout = 1'b0;
`ifdef RDT_FALSE_START_EN
               nxt_fs      = 1'b0;
`endif
               nxt_state   = WAIT_DELAY;
            end
         end
         WAIT_DELAY: begin
            busy = 1'b1;
`ifdef RDT_FALSE_START_EN
            if (react) begin
               nxt_fs    = 1'b1;
               nxt_delay = '0;
               nxt_state = RESULT;
            end else
`endif
            if (tick) begin
               // <= 1 rather than == 1 so a zero-length delay cannot wrap.
               if (delay_cnt <= ONE) begin
                  nxt_delay = '0;
                  nxt_state = WAIT_REACT;
               end else begin
                  nxt_delay = delay_cnt - 1'b1;
               end
            end
         end
         WAIT_REACT: begin
            busy = 1'b1;
            go   = 1'b1;
            // react has priority over a coincident tick: the count stays frozen.
            if (react) begin
               nxt_state = RESULT;
            end else if (tick) begin
               if (react_inc >= MAX_R) begin
                  nxt_react   = MAX_R;
                  nxt_timeout = 1'b1;
                  nxt_state   = RESULT;
               end else begin
                  nxt_react = react_inc;
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk50M or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         delay_cnt <= '0;
         react_cnt <= '0;
         timeout_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef RDT_FALSE_START_EN
         fs_q      <= 1'b0;
`endif
      end else begin
         state     <= nxt_state;
         delay_cnt <= nxt_delay;
         react_cnt <= nxt_react;
         timeout_q <= nxt_timeout;
         // Registered so the pulse lines up with the first cycle spent in RESULT.
         done_q    <= (nxt_state == RESULT) && (state != RESULT);
`ifdef RDT_FALSE_START_EN
         fs_q      <= nxt_fs;
`endif
      end
   end

   assign done        = done_q;
   assign timeout     = timeout_q;
   assign reaction_ms = react_cnt;
`ifdef RDT_FALSE_START_EN
   assign false_start = fs_q;
`else
   assign false_start = 1'b0;
`endif

endmodule

// File: tb/tb_random_delay_timer.sv
// Self-checking bench for random_delay_timer with a 10-cycle tick.
// Inputs driven 1 time unit after the rising edge; results popped from a
// scoreboard queue whenever done is seen on the falling edge.
module tb_random_delay_timer;

   logic        clk50M = 1'b0;
   logic        reset  = 1'b1;
   logic [11:0] random_num = '0;
   logic        start = 1'b0;
   logic        react = 1'b0;
   logic        go, busy, done, false_start, timeout;
   logic [13:0] reaction_ms;

   int checks   = 0;
   int errors   = 0;
   int cyc_n    = 0;
   int done_cnt = 0;

   typedef struct {
      int rm;
      int to;
      int fs;
   } exp_t;

   exp_t exp_q[$];

   random_delay_timer #(
      .CLK_HZ          (10),
      .TICK_HZ         (1),
      .MIN_DELAY_TICKS (2),
      .MAX_REACT_TICKS (20)
   ) dut (
      .clk50M      (clk50M),
      .reset       (reset),
      .random_num  (random_num),
      .start       (start),
      .react       (react),
      .go          (go),
      .busy        (busy),
      .done        (done),
      .false_start (false_start),
      .timeout     (timeout),
      .reaction_ms (reaction_ms)
   );

   always #5 clk50M = ~clk50M;

   always @(posedge clk50M) cyc_n++;

   task automatic chk(input string tag, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, act, expv);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk50M);
         #1;
      end
   endtask

   task automatic wait_go(input int t0, input int lat, input string tag);
      int n = 0;
      while (!go && n < 1000) begin
         cyc(1);
         n++;
      end
      chk(tag, go ? (cyc_n - t0) : -1, lat);
   endtask

   task automatic wait_done(input int base);
      int n = 0;
      while (done_cnt == base && n < 2000) begin
         cyc(1);
         n++;
      end
      chk("done_seen", int'(done_cnt > base), 1);
   endtask

   task automatic kick(input int rn, output int t0);
      random_num = 12'(rn);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      t0 = cyc_n;
   endtask

   // Scoreboard: each done pulse retires one expected result.
   always @(negedge clk50M) begin
      if (done) begin
         exp_t e;
         done_cnt++;
         chk("done_go", go, 0);
         chk("done_busy", busy, 0);
         if (exp_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("res_rm", int'(reaction_ms), e.rm);
            chk("res_timeout", timeout, e.to);
            chk("res_false_start", false_start, e.fs);
         end
      end
   end

   initial begin
      exp_t e;
      int   t0;
      int   d0;

      cyc(3);
      reset = 1'b0;
      cyc(2);
      chk("rst_go", go, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fs", false_start, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_rm", int'(reaction_ms), 0);

      // Run 1: delay 2+3 ticks, react after 7 ticks.
      d0 = done_cnt;
      kick(3, t0);
      chk("busy_after_start", busy, 1);
      chk("go_in_delay", go, 0);
      e = '{rm: 7, to: 0, fs: 0};
      exp_q.push_back(e);
      wait_go(t0, 50, "go_lat_rn3");
      cyc(70);
      chk("rm_before_react", int'(reaction_ms), 7);
      react = 1'b1;
      cyc(1);
      react = 1'b0;
      cyc(30);
      chk("done_once_1", done_cnt - d0, 1);
      chk("rm_hold", int'(reaction_ms), 7);
      chk("go_after_result", go, 0);
      chk("busy_after_result", busy, 0);

      // Run 2: zero random delay, starts while busy, react coinciding with 5th tick.
      d0 = done_cnt;
      kick(0, t0);
      e = '{rm: 4, to: 0, fs: 0};
      exp_q.push_back(e);
      cyc(5);
      random_num = 12'd100;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      random_num = '0;
      wait_go(t0, 20, "go_lat_rn0");
      cyc(29);
      random_num = 12'd50;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(19);
      chk("rm_pre_coincide", int'(reaction_ms), 4);
      react = 1'b1;
      cyc(1);
      react = 1'b0;
      wait_done(d0);
      cyc(5);
      chk("rm_coincide", int'(reaction_ms), 4);
      chk("done_once_2", done_cnt - d0, 1);

      // Run 3: no reaction -> timeout.
      d0 = done_cnt;
      kick(1, t0);
      e = '{rm: 20, to: 1, fs: 0};
      exp_q.push_back(e);
      wait_go(t0, 30, "go_lat_rn1");
      wait_done(d0);
      cyc(3);
      chk("to_flag", timeout, 1);
      chk("to_rm", int'(reaction_ms), 20);
      chk("to_go", go, 0);
      chk("done_once_3", done_cnt - d0, 1);

      // Run 4: press during the delay.
      d0 = done_cnt;
      kick(2, t0);
      cyc(15);
`ifdef RDT_FALSE_START_EN
      e = '{rm: 0, to: 0, fs: 1};
      exp_q.push_back(e);
      react = 1'b1;
      cyc(1);
      react = 1'b0;
      wait_done(d0);
      cyc(2);
      chk("fs_flag", false_start, 1);
      chk("fs_rm", int'(reaction_ms), 0);
      chk("fs_go", go, 0);
`else
      react = 1'b1;
      cyc(1);
      react = 1'b0;
      chk("fs_tied", false_start, 0);
      chk("early_react_busy", busy, 1);
      wait_go(t0, 40, "go_lat_early_react");
      e = '{rm: 0, to: 0, fs: 0};
      exp_q.push_back(e);
      react = 1'b1;
      cyc(1);
      react = 1'b0;
      wait_done(d0);
`endif

      // Run 5: reset in WAIT_REACT, then a normal run.
      d0 = done_cnt;
      kick(0, t0);
      wait_go(t0, 20, "go_lat_pre_reset");
      cyc(25);
      chk("rm_pre_reset", int'(reaction_ms), 2);
      reset = 1'b1;
      #1;
      chk("mid_rst_go", go, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_fs", false_start, 0);
      chk("mid_rst_timeout", timeout, 0);
      chk("mid_rst_rm", int'(reaction_ms), 0);
      cyc(2);
      reset = 1'b0;
      cyc(3);
      chk("no_done_on_reset", done_cnt - d0, 0);
      kick(5, t0);
      e = '{rm: 3, to: 0, fs: 0};
      exp_q.push_back(e);
      wait_go(t0, 70, "go_lat_post_reset");
      cyc(30);
      react = 1'b1;
      cyc(1);
      react = 1'b0;
      wait_done(d0);
      cyc(2);
      chk("rm_post_reset", int'(reaction_ms), 3);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
